cache_mem_arbiter: RTL and testbench

//  Shares the single memory port between the I-cache refill path and the D-cache refill/writeback path.

---
 rtl/cache_mem_arbiter_if.sv | 48 ++++
 rtl/cache_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, the shared memory port and the arbiter.
// The arbiter connects through slave; the requesters and memory model connect through master.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [31:0]       ic_rdata;
    logic              ic_ok;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [7:0]        dc_wmask;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ok;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ok;

    logic              busy;
    logic              err;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata, dc_wmask,
        input  mem_rdata, mem_ok,
        output ic_rdata, ic_ok, dc_rdata, dc_ok,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output busy, err
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata, dc_wmask,
        output mem_rdata, mem_ok,
        input  ic_rdata, ic_ok, dc_rdata, dc_ok,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  busy, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin owner of the single memory port, shared by I-cache refills and D-cache refills/writebacks.
// One transaction in flight; a watchdog aborts a transaction the memory never completes.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                clk,
    input logic                rst,
    cache_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Count value during the last BUSY cycle allowed before the abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic              to_flag;
    logic [7:0]        cnt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    logic [31:0]       ic_rdata_q;
    logic [DATA_W-1:0] dc_rdata_q;

    logic              grant_any;
    logic              grant_d;
    logic              timeout_hit;
    logic              in_busy;
    logic              finish;

    function automatic logic [31:0] ic_word(input logic hi, input logic [DATA_W-1:0] data);
        return hi ? data[63:32] : data[31:0];
    endfunction

    always_comb begin
        grant_any   = bus.ic_req | bus.dc_req;
        grant_d     = bus.dc_req & (~bus.ic_req | (last_grant == OWN_I));
        in_busy     = (state == BUSY);
        timeout_hit = in_busy & ~bus.mem_ok & (cnt == TO_LAST);
        finish      = in_busy & (bus.mem_ok | timeout_hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_D;
            to_flag    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state      <= BUSY;
                        owner      <= grant_d;
                        last_grant <= grant_d;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (bus.mem_ok) begin
                        state <= RESP;
                    end else if (timeout_hit) begin
                        state   <= RESP;
                        to_flag <= 1'b1;
                    end
                end
                RESP: state <= REL;
                REL: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    to_flag <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Attributes captured at grant; requesters are free to change inputs afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_any) begin
            we_q    <= grant_d & bus.dc_we;
            addr_q  <= grant_d ? bus.dc_addr : bus.ic_addr;
            wdata_q <= grant_d ? bus.dc_wdata : '0;
            wmask_q <= grant_d ? bus.dc_wmask : '0;
        end
    end

    // Read data registers hold their value between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else if (finish) begin
            if (owner == OWN_I) begin
                ic_rdata_q <= bus.mem_ok ? ic_word(addr_q[2], bus.mem_rdata) : '0;
            end else begin
                dc_rdata_q <= (bus.mem_ok && !we_q) ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.mem_req   = in_busy;
    assign bus.mem_we    = in_busy & we_q;
    assign bus.mem_addr  = in_busy ? addr_q  : '0;
    assign bus.mem_wdata = in_busy ? wdata_q : '0;
    assign bus.mem_wmask = in_busy ? wmask_q : '0;

    assign bus.ic_ok    = (state == RESP) & (owner == OWN_I);
    assign bus.dc_ok    = (state == RESP) & (owner == OWN_D);
    assign bus.err      = (state == RESP) & to_flag;
    assign bus.busy     = (state != IDLE);
    assign bus.ic_rdata = ic_rdata_q;
    assign bus.dc_rdata = dc_rdata_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    localparam int ADDR_W      = 64;
    localparam int DATA_W      = 64;
    localparam int TIMEOUT_CYC = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: mem_ok arrives mem_lat cycles after mem_req first rises.
    int          mem_lat  = 3;
    bit          mem_hang = 1'b0;
    logic [63:0] mem_data = 64'd0;
    int          req_age  = 0;

    always @(posedge clk) begin
        #1;
        bus.mem_ok = 1'b0;
        if (bus.mem_req === 1'b1) begin
            if (!mem_hang && req_age == mem_lat) begin
                bus.mem_ok    = 1'b1;
                bus.mem_rdata = mem_data;
            end
            req_age++;
        end else begin
            req_age = 0;
        end
    end

    // Reference: one transaction record plus the cycle numbers of its grant and end.
    int          cyc        = 0;
    logic        m_active   = 1'b0;
    logic        m_owner    = 1'b0;
    logic        m_last     = 1'b1;
    logic        m_we       = 1'b0;
    logic        m_to       = 1'b0;
    logic [63:0] m_addr     = 64'd0;
    logic [63:0] m_wdata    = 64'd0;
    logic [7:0]  m_wmask    = 8'd0;
    int          m_grant    = 0;
    int          m_end      = -1;
    logic [31:0] e_ic_rdata = 32'd0;
    logic [63:0] e_dc_rdata = 64'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active   = 1'b0;
            m_end      = -1;
            m_to       = 1'b0;
            m_last     = 1'b1;
            e_ic_rdata = 32'd0;
            e_dc_rdata = 64'd0;
        end else begin
            cyc++;
            if (m_active && m_end < 0) begin
                if (bus.mem_ok) begin
                    m_end = cyc;
                    m_to  = 1'b0;
                    if (!m_owner) e_ic_rdata = m_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                    else          e_dc_rdata = m_we ? 64'd0 : bus.mem_rdata;
                end else if (cyc - m_grant == TIMEOUT_CYC) begin
                    m_end = cyc;
                    m_to  = 1'b1;
                    if (!m_owner) e_ic_rdata = 32'd0;
                    else          e_dc_rdata = 64'd0;
                end
            end else if (m_active && cyc == m_end + 2) begin
                m_active = 1'b0;
            end else if (!m_active && (bus.ic_req || bus.dc_req)) begin
                m_owner  = (bus.ic_req && bus.dc_req) ? ~m_last : bus.dc_req;
                m_last   = m_owner;
                m_active = 1'b1;
                m_grant  = cyc;
                m_end    = -1;
                m_to     = 1'b0;
                m_we     = m_owner & bus.dc_we;
                m_addr   = m_owner ? bus.dc_addr  : bus.ic_addr;
                m_wdata  = m_owner ? bus.dc_wdata : 64'd0;
                m_wmask  = m_owner ? bus.dc_wmask : 8'd0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic exp_req;
        logic exp_resp;
        exp_req  = m_active && (m_end < 0);
        exp_resp = m_active && (m_end == cyc) && rst;
        check("busy",      bus.busy,      m_active);
        check("mem_req",   bus.mem_req,   exp_req);
        check("mem_we",    bus.mem_we,    exp_req ? m_we : 1'b0);
        check("mem_addr",  bus.mem_addr,  exp_req ? m_addr : 64'd0);
        check("mem_wdata", bus.mem_wdata, exp_req ? m_wdata : 64'd0);
        check("mem_wmask", bus.mem_wmask, exp_req ? m_wmask : 8'd0);
        check("ic_ok",     bus.ic_ok,     exp_resp && !m_owner);
        check("dc_ok",     bus.dc_ok,     exp_resp && m_owner);
        check("err",       bus.err,       exp_resp && m_to);
        check("ic_rdata",  bus.ic_rdata,  e_ic_rdata);
        check("dc_rdata",  bus.dc_rdata,  e_dc_rdata);
    end

    task automatic run_txn(input bit drop, output logic who_d, output int reqc,
                           output logic [31:0] ic_d, output logic [63:0] dc_d,
                           output logic e, output logic got);
        got = 1'b0; who_d = 1'b0; reqc = 0; ic_d = '0; dc_d = '0; e = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_req) reqc++;
            if (bus.ic_ok || bus.dc_ok) begin
                got   = 1'b1;
                who_d = bus.dc_ok;
                ic_d  = bus.ic_rdata;
                dc_d  = bus.dc_rdata;
                e     = bus.err;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL txn_done: no ok pulse within 400 cycles, got 0 required 1");
        end else if (drop) begin
            @(posedge clk); #1;
            if (who_d) bus.dc_req = 1'b0;
            else       bus.ic_req = 1'b0;
        end
    endtask

    task automatic wait_mem_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        who, e, got;
        int          reqc, okc;
        logic [31:0] icd;
        logic [63:0] dcd;
        logic [3:0]  order;

        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0;
        bus.dc_wdata = '0; bus.dc_wmask = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_ic_rdata", bus.ic_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // I-cache read, upper word selected by addr[2]
        mem_lat = 3; mem_data = 64'h1111_2222_3333_4444;
        bus.ic_addr = 64'h8000_0004; bus.ic_req = 1'b1;
        run_txn(1'b1, who, reqc, icd, dcd, e, got);
        check("t1_owner", who, 1'b0);
        check("t1_req_cycles", reqc, 4);
        check("t1_ic_rdata", icd, 32'h1111_2222);
        check("t1_err", e, 1'b0);

        // D-cache write carries latched fields, reads back 0
        mem_lat = 2; mem_data = 64'h9999_8888_7777_6666;
        bus.dc_we = 1'b1; bus.dc_addr = 64'h8000_1000;
        bus.dc_wdata = 64'hDEAD_BEEF_0000_0001; bus.dc_wmask = 8'h0F; bus.dc_req = 1'b1;
        wait_mem_req("t2_mem_req_rise");
        check("t2_mem_we", bus.mem_we, 1'b1);
        check("t2_mem_addr", bus.mem_addr, 64'h8000_1000);
        check("t2_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_0001);
        check("t2_mem_wmask", bus.mem_wmask, 8'h0F);
        run_txn(1'b1, who, reqc, icd, dcd, e, got);
        check("t2_owner", who, 1'b1);
        check("t2_dc_rdata", dcd, 64'd0);
        bus.dc_we = 1'b0; bus.dc_wmask = 8'h00;

        // Fresh reset, both requesting: strict alternation starting with I
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        mem_lat = 0; mem_data = 64'hA5A5_0000_0000_5A5A;
        bus.ic_addr = 64'h40; bus.dc_addr = 64'h80;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        order = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, who, reqc, icd, dcd, e, got);
            order[k] = who;
            if (k == 3) begin
                bus.ic_req = 1'b0; bus.dc_req = 1'b0;
            end else begin
                @(posedge clk); #1;
                if (who) bus.dc_req = 1'b1;
                else     bus.ic_req = 1'b1;
            end
        end
        check("t3_grant_order", order, 4'b1010);
        check("t3_ic_rdata", bus.ic_rdata, 32'h0000_5A5A);
        repeat (3) @(posedge clk); #1;

        // Address changes during BUSY are not seen by memory
        mem_lat = 36; mem_data = 64'hCAFE_F00D_1234_5678;
        bus.dc_we = 1'b0; bus.dc_addr = 64'h100; bus.dc_req = 1'b1;
        fork
            run_txn(1'b1, who, reqc, icd, dcd, e, got);
            begin
                repeat (6) @(posedge clk); #1;
                bus.dc_addr = 64'h200;
                @(negedge clk);
                check("t4_mem_addr_held", bus.mem_addr, 64'h100);
            end
        join
        check("t4_owner", who, 1'b1);
        check("t4_req_cycles", reqc, 37);
        check("t4_dc_rdata", dcd, 64'hCAFE_F00D_1234_5678);

        // Hung memory: watchdog abort
        mem_hang = 1'b1;
        bus.ic_addr = 64'h8000_0000; bus.ic_req = 1'b1;
        run_txn(1'b1, who, reqc, icd, dcd, e, got);
        check("t5_owner", who, 1'b0);
        check("t5_req_cycles", reqc, 255);
        check("t5_err", e, 1'b1);
        check("t5_ic_rdata", icd, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_after", bus.busy, 1'b0);
        mem_hang = 1'b0;

        // Reset in BUSY kills the transaction; pending D is served after release
        mem_lat = 5; mem_data = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.dc_addr = 64'h300; bus.dc_req = 1'b1;
        wait_mem_req("t6_mem_req_rise");
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_mem_req_async", bus.mem_req, 1'b0);
        check("t6_busy_async", bus.busy, 1'b0);
        okc = 0;
        repeat (3) begin
            @(negedge clk);
            okc += int'(bus.ic_ok) + int'(bus.dc_ok);
        end
        check("t6_no_ok", okc, 0);
        @(posedge clk); #1 rst = 1'b1;
        run_txn(1'b1, who, reqc, icd, dcd, e, got);
        check("t6_pending_d", who, 1'b1);
        check("t6_dc_rdata", dcd, 64'h0BAD_0BAD_0BAD_0BAD);
        @(posedge clk); #1 rst = 1'b0;
        bus.ic_addr = 64'h8; bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        run_txn(1'b1, who, reqc, icd, dcd, e, got);
        check("t6_tie_to_i", who, 1'b0);
        check("t6_ic_rdata", icd, 32'h0BAD_0BAD);
        bus.dc_req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
